dvi_pattern_generator: RTL and testbench
========================================

// Module: dvi_pattern_generator
// PURPOSE
// - Parametrised successor of the fixed 720p DVI test-pattern driver. Generates H/V timing
//   (back porch, active, front porch, sync) plus a 9-position calibration marker or solid fill.
// - Outputs a registered RGB pixel stream with de/hs/vs; ODDR/pin mapping lives in a separate wrapper.
// - Feeds the latency-measurement path: tick marks the marker centre pixel.
// PARAMETERS
// - H_BACK_PORCH   220   horizontal back porch, clocks (>=1)
// - H_ACTIVE       1280  active pixels per line (>=2*MARKER_RADIUS+1, even)
// - H_FRONT_PORCH  110   horizontal front porch, clocks (>=1)
// - H_SYNC         40    hsync width, clocks (>=1)
// - V_BACK_PORCH   20    vertical back porch, lines (>=1)
// - V_ACTIVE       720   active lines (>=2*MARKER_RADIUS+1, even)
// - V_FRONT_PORCH  5     vertical front porch, lines (>=1)
// - V_SYNC         5     vsync width, lines (>=1)
// - MARKER_RADIUS  2     marker half-size; marker is (2R+1)x(2R+1) pixels
// - HS_POLARITY    1     1 = hsync active high, 0 = active low
// - VS_POLARITY    1     1 = vsync active high, 0 = active low
// - MARKER_RGB     24'hFFFFFF  colour of marker / solid fill
// PORTS
// - clk          in   1   pixel clock
// - resetn       in   1   asynchronous, active-low reset
// - ready        in   1   clock enable (downstream PLL/encoder locked)
// - enable       in   1   async; marker/fill output enable
// - pattern      in   4   async; pattern select
// - active       out  1   data enable
// - hsync        out  1   horizontal sync, polarity per HS_POLARITY
// - vsync        out  1   vertical sync, polarity per VS_POLARITY
// - data         out  24  RGB pixel, {R,G,B}
// - tick         out  1   1-cycle pulse coincident with marker centre pixel
// - frame_start  out  1   1-cycle pulse coincident with first output cycle of V back porch
// BEHAVIOUR
// - Reset: active=0, tick=0, frame_start=0, data=0, hsync/vsync at inactive level; both FSMs in
//   BACK_PORCH, counts 0, enabled=0, latched pattern=0.
// - H FSM BACK_PORCH->ACTIVE->FRONT_PORCH->SYNC->BACK_PORCH, each after its length in clocks;
//   count resets to 0 on every transition. V FSM uses the same order and steps once per line,
//   on the last H_SYNC clock. Counter width = $clog2 of the largest segment length.
// - When ready=1 the counters advance; outputs are registered from the current state, so
//   outputs lag the counters by exactly 1 clk.
// - When ready=0: counters hold; active/hsync/vsync hold; data=0, tick=0, frame_start=0.
// - enable passes a 2-flop synchroniser; pattern passes a 2-flop synchroniser. Both are latched
//   into working registers only while V state != ACTIVE; a change mid-frame takes effect at the
//   next frame. There is no tearing.
// - active = (V==ACTIVE && H==ACTIVE). data=0 whenever active=0 or enabled=0.
// - Marker H range per pattern%3:
//   - 0: [0,2R], centre R
//   - 1: [H_ACTIVE/2-R, H_ACTIVE/2+R], centre H_ACTIVE/2
//   - 2: [H_ACTIVE-2R-1, H_ACTIVE-1], centre H_ACTIVE-R-1
// - Marker V range per pattern/3 (rows 0..2) follows the same rule using V_ACTIVE.
// - Patterns 0-8: data=MARKER_RGB inside both ranges, else 0; tick on the centre pixel.
//   Pattern 9: data=MARKER_RGB on every active pixel; tick on pixel (0,0).
//   Patterns 10-15: data=0, tick never (except 10 with the option below).
// - tick only while enabled=1. Reset mid-frame returns immediately to the reset state.
// CONFIGURATION
// - DVI_PATTERN_COLOR_BARS_EN defined: pattern 10 = 8 vertical bars, each H_ACTIVE/8 wide, in order
//   white, yellow, cyan, green, magenta, red, blue, black (full-scale 8'hFF/8'h00 components).
//   tick pulses on pixel (0,0).
// - DVI_PATTERN_COLOR_BARS_EN undefined: pattern 10 behaves as 11-15 (black, no tick). No bar logic is synthesised.
// TESTING
// - Bench timing: H 4/16/2/2, V 2/8/1/1, R=1; line=24 clk, frame=288 clk.
// - Reset, ready=1 -> first active=1 at clk 2*24+4+1 after release. hsync high 2 clk of every 24.
//   vsync high 24 clk of every 288. frame_start every 288 clk.
// - enable=1, pattern=4 -> data=FFFFFF for h 7..9, lines 3..5 only. tick once per frame at (8,4).
// - pattern=8 -> marker h 13..15, v 5..7; tick at (14,6). pattern=0 -> marker h 0..2, v 0..2; tick at (1,1).
// - Change pattern 0->2 mid-active-frame -> current frame still pattern 0; next frame pattern 2.
// - ready=0 for 10 clk mid-line -> counters frozen, data=0, tick=0; line resumes, total count unchanged.
// - HS_POLARITY=0, VS_POLARITY=0 -> reset levels 1. Sync pulses low. With COLOR_BARS_EN, pattern 10 -> bars 2 px wide, h 14..15 = 000000.

Source files
------------

// File: rtl/dvi_pattern_generator.sv
// Parametrised DVI timing and test-pattern generator: H/V timing, calibration marker, solid fill.
// Optional colour-bar pattern 10 is built when DVI_PATTERN_COLOR_BARS_EN is defined.
module dvi_pattern_generator #(
   parameter int          H_BACK_PORCH  = 220,
   parameter int          H_ACTIVE      = 1280,
   parameter int          H_FRONT_PORCH = 110,
   parameter int          H_SYNC        = 40,
   parameter int          V_BACK_PORCH  = 20,
   parameter int          V_ACTIVE      = 720,
   parameter int          V_FRONT_PORCH = 5,
   parameter int          V_SYNC        = 5,
   parameter int          MARKER_RADIUS = 2,
   parameter int          HS_POLARITY   = 1,
   parameter int          VS_POLARITY   = 1,
   parameter logic [23:0] MARKER_RGB    = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ready,
   input  logic        enable,
   input  logic [3:0]  pattern,
   output logic        active,
   output logic        hsync,
   output logic        vsync,
   output logic [23:0] data,
   output logic        tick,
   output logic        frame_start
);

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > d) ? m : d;
   endfunction

   localparam int H_MAX = max4(H_BACK_PORCH, H_ACTIVE, H_FRONT_PORCH, H_SYNC);
   localparam int V_MAX = max4(V_BACK_PORCH, V_ACTIVE, V_FRONT_PORCH, V_SYNC);
   localparam int H_CW  = (H_MAX > 1) ? $clog2(H_MAX) : 1;
   localparam int V_CW  = (V_MAX > 1) ? $clog2(V_MAX) : 1;
   localparam logic HS_ON = (HS_POLARITY != 0);
   localparam logic VS_ON = (VS_POLARITY != 0);
   localparam int R = MARKER_RADIUS;

   typedef enum logic [1:0] {SEG_BACK, SEG_ACTIVE, SEG_FRONT, SEG_SYNC} seg_e;

   seg_e            h_state_q, h_state_d, v_state_q, v_state_d;
   logic [H_CW-1:0] h_cnt_q, h_cnt_d, h_last;
   logic [V_CW-1:0] v_cnt_q, v_cnt_d, v_last;
   logic [1:0]      en_sync_q, en_sync_d;
   logic [3:0]      pat_meta_q, pat_meta_d, pat_sync_q, pat_sync_d;
   logic            enabled_q, enabled_d;
   logic [3:0]      pattern_q, pattern_d;
   logic            active_d, hsync_d, vsync_d, tick_d, frame_start_d;
   logic [23:0]     data_d;
   logic [1:0]      col, row;
   logic [H_CW-1:0] h_lo, h_hi, h_c;
   logic [V_CW-1:0] v_lo, v_hi, v_c;
   logic            in_active, pix_on, pix_tick;
   logic [23:0]     pix_rgb;

   // State register: timing counters plus the synchronised and frame-latched controls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         h_state_q   <= SEG_BACK;
         v_state_q   <= SEG_BACK;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         en_sync_q   <= '0;
         pat_meta_q  <= '0;
         pat_sync_q  <= '0;
         enabled_q   <= 1'b0;
         pattern_q   <= '0;
         active      <= 1'b0;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         data        <= '0;
         tick        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         h_state_q   <= h_state_d;
         v_state_q   <= v_state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         en_sync_q   <= en_sync_d;
         pat_meta_q  <= pat_meta_d;
         pat_sync_q  <= pat_sync_d;
         enabled_q   <= enabled_d;
         pattern_q   <= pattern_d;
         active      <= active_d;
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         data        <= data_d;
         tick        <= tick_d;
         frame_start <= frame_start_d;
      end
   end

   // Next state: V steps once per line, on the last clock of H sync.
   always_comb begin
      h_state_d = h_state_q;
      v_state_d = v_state_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      case (h_state_q)
         SEG_BACK:   h_last = H_CW'(H_BACK_PORCH - 1);
         SEG_ACTIVE: h_last = H_CW'(H_ACTIVE - 1);
         SEG_FRONT:  h_last = H_CW'(H_FRONT_PORCH - 1);
         default:    h_last = H_CW'(H_SYNC - 1);
      endcase
      case (v_state_q)
         SEG_BACK:   v_last = V_CW'(V_BACK_PORCH - 1);
         SEG_ACTIVE: v_last = V_CW'(V_ACTIVE - 1);
         SEG_FRONT:  v_last = V_CW'(V_FRONT_PORCH - 1);
         default:    v_last = V_CW'(V_SYNC - 1);
      endcase
      if (ready) begin
         if (h_cnt_q == h_last) begin
            h_cnt_d   = '0;
            h_state_d = seg_e'(h_state_q + 2'd1);
            if (h_state_q == SEG_SYNC) begin
               if (v_cnt_q == v_last) begin
                  v_cnt_d   = '0;
                  v_state_d = seg_e'(v_state_q + 2'd1);
               end else begin
                  v_cnt_d = v_cnt_q + V_CW'(1);
               end
            end
         end else begin
            h_cnt_d = h_cnt_q + H_CW'(1);
         end
      end
      // Controls only update outside the active lines so a frame never tears.
      en_sync_d  = {en_sync_q[0], enable};
      pat_meta_d = pattern;
      pat_sync_d = pat_meta_q;
      enabled_d  = (v_state_q != SEG_ACTIVE) ? en_sync_q[1] : enabled_q;
      pattern_d  = (v_state_q != SEG_ACTIVE) ? pat_sync_q : pattern_q;
   end

   // Output decode: marker window from the pattern's column/row, then registered outputs.
   always_comb begin
      case (pattern_q)
         4'd0, 4'd3, 4'd6: col = 2'd0;
         4'd1, 4'd4, 4'd7: col = 2'd1;
         default:          col = 2'd2;
      endcase
      case (pattern_q)
         4'd0, 4'd1, 4'd2: row = 2'd0;
         4'd3, 4'd4, 4'd5: row = 2'd1;
         default:          row = 2'd2;
      endcase
      case (col)
         2'd0:    begin h_lo = '0; h_hi = H_CW'(2*R); h_c = H_CW'(R); end
         2'd1:    begin h_lo = H_CW'(H_ACTIVE/2 - R); h_hi = H_CW'(H_ACTIVE/2 + R); h_c = H_CW'(H_ACTIVE/2); end
         default: begin h_lo = H_CW'(H_ACTIVE - 2*R - 1); h_hi = H_CW'(H_ACTIVE - 1); h_c = H_CW'(H_ACTIVE - R - 1); end
      endcase
      case (row)
         2'd0:    begin v_lo = '0; v_hi = V_CW'(2*R); v_c = V_CW'(R); end
         2'd1:    begin v_lo = V_CW'(V_ACTIVE/2 - R); v_hi = V_CW'(V_ACTIVE/2 + R); v_c = V_CW'(V_ACTIVE/2); end
         default: begin v_lo = V_CW'(V_ACTIVE - 2*R - 1); v_hi = V_CW'(V_ACTIVE - 1); v_c = V_CW'(V_ACTIVE - R - 1); end
      endcase
      pix_rgb  = MARKER_RGB;
      pix_on   = 1'b0;
      pix_tick = 1'b0;
      if (pattern_q <= 4'd8) begin
         pix_on   = (h_cnt_q >= h_lo) && (h_cnt_q <= h_hi) && (v_cnt_q >= v_lo) && (v_cnt_q <= v_hi);
         pix_tick = (h_cnt_q == h_c) && (v_cnt_q == v_c);
      end else if (pattern_q == 4'd9) begin
         pix_on   = 1'b1;
         pix_tick = (h_cnt_q == '0) && (v_cnt_q == '0);
      end
`ifdef DVI_PATTERN_COLOR_BARS_EN
      else if (pattern_q == 4'd10) begin
         pix_on   = 1'b1;
         pix_tick = (h_cnt_q == '0) && (v_cnt_q == '0);
         case (int'(h_cnt_q) / ((H_ACTIVE >= 8) ? H_ACTIVE/8 : 1))
            0:       pix_rgb = 24'hFFFFFF;
            1:       pix_rgb = 24'hFFFF00;
            2:       pix_rgb = 24'h00FFFF;
            3:       pix_rgb = 24'h00FF00;
            4:       pix_rgb = 24'hFF00FF;
            5:       pix_rgb = 24'hFF0000;
            6:       pix_rgb = 24'h0000FF;
            default: pix_rgb = 24'h000000;
         endcase
      end
`endif
      in_active     = (v_state_q == SEG_ACTIVE) && (h_state_q == SEG_ACTIVE);
      active_d      = ready ? in_active : active;
      hsync_d       = ready ? ((h_state_q == SEG_SYNC) ? HS_ON : ~HS_ON) : hsync;
      vsync_d       = ready ? ((v_state_q == SEG_SYNC) ? VS_ON : ~VS_ON) : vsync;
      data_d        = (ready && in_active && enabled_q && pix_on) ? pix_rgb : 24'h0;
      tick_d        = ready && in_active && enabled_q && pix_tick;
      frame_start_d = ready && (v_state_q == SEG_BACK) && (v_cnt_q == '0) &&
                      (h_state_q == SEG_BACK) && (h_cnt_q == '0);
   end

endmodule

// File: tb/tb_dvi_pattern_generator.sv
// Randomised scoreboard bench for dvi_pattern_generator using small timing (24x12 frame).
// A frame-position model predicts each registered output; a negedge monitor compares.
module tb_dvi_pattern_generator;

   localparam int HB = 4, HA = 16, HF = 2, HS = 2;
   localparam int VB = 2, VA = 8, VF = 1, VS = 1;
   localparam int R = 1;
   localparam int LINE  = HB + HA + HF + HS;
   localparam int FRAME = LINE * (VB + VA + VF + VS);

   typedef struct packed {
      logic        active;
      logic        hsync;
      logic        vsync;
      logic [23:0] data;
      logic        tick;
      logic        frame_start;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ready = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  pattern = 4'd0;
   logic        active, hsync, vsync, tick, frame_start;
   logic [23:0] data;
   logic        active_n, hsync_n, vsync_n, tick_n, frame_start_n;
   logic [23:0] data_n;

   exp_t exp_q[$];
   int   check_cnt = 0;
   int   pass_cnt  = 0;

   int          pos;
   logic [1:0]  en_sh;
   logic [3:0]  pat_sh0, pat_sh1, pat_m;
   logic        en_m;
   exp_t        last_e;

   dvi_pattern_generator #(
      .H_BACK_PORCH(HB), .H_ACTIVE(HA), .H_FRONT_PORCH(HF), .H_SYNC(HS),
      .V_BACK_PORCH(VB), .V_ACTIVE(VA), .V_FRONT_PORCH(VF), .V_SYNC(VS),
      .MARKER_RADIUS(R), .HS_POLARITY(1), .VS_POLARITY(1), .MARKER_RGB(24'hFFFFFF)
   ) dut (
      .clk(clk), .resetn(resetn), .ready(ready), .enable(enable), .pattern(pattern),
      .active(active), .hsync(hsync), .vsync(vsync), .data(data), .tick(tick),
      .frame_start(frame_start)
   );

   dvi_pattern_generator #(
      .H_BACK_PORCH(HB), .H_ACTIVE(HA), .H_FRONT_PORCH(HF), .H_SYNC(HS),
      .V_BACK_PORCH(VB), .V_ACTIVE(VA), .V_FRONT_PORCH(VF), .V_SYNC(VS),
      .MARKER_RADIUS(R), .HS_POLARITY(0), .VS_POLARITY(0), .MARKER_RGB(24'hFFFFFF)
   ) dut_n (
      .clk(clk), .resetn(resetn), .ready(ready), .enable(enable), .pattern(pattern),
      .active(active_n), .hsync(hsync_n), .vsync(vsync_n), .data(data_n), .tick(tick_n),
      .frame_start(frame_start_n)
   );

   always #5 clk = ~clk;

   // Expected outputs after one clock, from the frame position at the moment of the edge.
   function automatic exp_t predict(input int p, input logic rdy, input logic en,
                                    input logic [3:0] pat, input exp_t prev);
      exp_t e;
      int line, colp, x, y, cx, cy;
      logic h_act, v_act, on, tk;
      logic [23:0] rgb;
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      line  = p / LINE;
      colp  = p % LINE;
      h_act = (colp >= HB) && (colp < HB + HA);
      v_act = (line >= VB) && (line < VB + VA);
      x     = colp - HB;
      y     = line - VB;
      on    = 1'b0;
      tk    = 1'b0;
      rgb   = 24'hFFFFFF;
      if (pat <= 4'd8) begin
         cx = (pat % 3 == 0) ? R : (pat % 3 == 1) ? HA / 2 : HA - R - 1;
         cy = (pat / 3 == 0) ? R : (pat / 3 == 1) ? VA / 2 : VA - R - 1;
         on = (x >= cx - R) && (x <= cx + R) && (y >= cy - R) && (y <= cy + R);
         tk = (x == cx) && (y == cy);
      end else if (pat == 4'd9) begin
         on = 1'b1;
         tk = (x == 0) && (y == 0);
      end
`ifdef DVI_PATTERN_COLOR_BARS_EN
      else if (pat == 4'd10) begin
         on  = 1'b1;
         tk  = (x == 0) && (y == 0);
         rgb = (h_act && x / (HA / 8) < 8) ? bars[x / (HA / 8)] : 24'h0;
      end
`endif
      if (!rdy) begin
         e = '{active: prev.active, hsync: prev.hsync, vsync: prev.vsync,
               data: 24'h0, tick: 1'b0, frame_start: 1'b0};
      end else begin
         e.active      = h_act && v_act;
         e.hsync       = (colp >= HB + HA + HF);
         e.vsync       = (line >= VB + VA + VF);
         e.data        = (h_act && v_act && en && on) ? rgb : 24'h0;
         e.tick        = h_act && v_act && en && tk;
         e.frame_start = (p == 0);
      end
      return e;
   endfunction

   // Reference model: push one expected output per clock while out of reset.
   always @(posedge clk) begin
      if (!resetn) begin
         pos     = 0;
         en_sh   = '0;
         pat_sh0 = '0;
         pat_sh1 = '0;
         en_m    = 1'b0;
         pat_m   = '0;
         last_e  = '0;
      end else begin
         last_e = predict(pos, ready, en_m, pat_m, last_e);
         exp_q.push_back(last_e);
         if (!((pos / LINE >= VB) && (pos / LINE < VB + VA))) begin
            en_m  = en_sh[1];
            pat_m = pat_sh1;
         end
         en_sh   = {en_sh[0], enable};
         pat_sh1 = pat_sh0;
         pat_sh0 = pattern;
         if (ready) pos = (pos + 1) % FRAME;
      end
   end

   task automatic compare(input string name, input logic [28:0] got, input logic [28:0] want);
      check_cnt++;
      if (got === want) pass_cnt++;
      else $display("[TB] FAIL %s at %0t: got %h required %h", name, $time, got, want);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (!resetn) begin
         exp_q.delete();
         compare("reset_state", {active, hsync, vsync, data, tick, frame_start}, 29'h0);
         compare("reset_sync_lowpol", {27'h0, hsync_n, vsync_n}, 29'h3);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare("outputs", {active, hsync, vsync, data, tick, frame_start}, e);
         compare("sync_lowpol", {27'h0, hsync_n, vsync_n}, {27'h0, ~e.hsync, ~e.vsync});
      end
   endtask

   always @(negedge clk) checkOutput();

   task automatic applyStimulus(input int cycles, input int ready_pct,
                                input logic en, input logic [3:0] pat);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #2;
         ready   = ($urandom_range(0, 99) < ready_pct);
         enable  = en;
         pattern = pat;
      end
   endtask

   initial begin
      ready   = 1'b1;
      enable  = 1'b1;
      pattern = 4'd4;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd4);
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd8);
      applyStimulus(FRAME + 100, 100, 1'b1, 4'd0);
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd2);
      applyStimulus(130, 100, 1'b1, 4'd2);
      applyStimulus(10, 0, 1'b1, 4'd2);
      applyStimulus(FRAME, 100, 1'b1, 4'd2);
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd9);
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd10);
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd13);
      for (int k = 0; k < 20; k++) begin
         applyStimulus($urandom_range(50, 400), 85, ($urandom_range(0, 4) != 0),
                       4'($urandom_range(0, 15)));
      end
      applyStimulus(150, 100, 1'b1, 4'd6);
      @(posedge clk);
      #2 resetn = 1'b0;
      applyStimulus(3, 100, 1'b1, 4'd6);
      @(posedge clk);
      #2 resetn = 1'b1;
      applyStimulus(2 * FRAME, 100, 1'b1, 4'd6);
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
